up_counter: RTL and testbench

Parameterised up counter, the counting-up counterpart to the team's down counter. It counts from 0 toward a programmable terminal value `limit`. On reaching it, the counter either wraps to 0 (free-running) or stops and flags `done` (one-shot). It provides a combinational `overflow` strobe and a sticky overflow status bit, for event counting, tick generation and timeout detection in sequential-circuit designs.

---
 rtl/counter_pkg.sv | 11 +
 rtl/up_counter.sv | 75 +++++++
 tb/tb_up_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions used by the up and down counters and their benches.
package counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } cnt_state_t;

  localparam int DEFAULT_CNT_WIDTH = 4;

endpackage

// File: rtl/up_counter.sv
// Up counter toward a programmable terminal value, with free-running wrap or
// one-shot stop, a combinational overflow strobe and a sticky overflow flag.
module up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             one_shot,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic             done
);

  // state | meaning
  // RUN   | counting (or holding while en=0)
  // DONE  | one-shot terminal reached; en ignored until clr/load

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             sticky_q, sticky_d;
  logic             at_limit;

  assign at_limit = (count_q == limit);

  // rst_n gating keeps the strobe low while reset is held, even with limit=0.
  assign overflow = at_limit & en & (state_q == RUN) & ~clr & ~load & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clr) begin
      state_d = RUN;
      count_d = '0;
    end else if (load) begin
      state_d = RUN;
      count_d = load_val;
    end else if (state_q == RUN && en) begin
      if (!at_limit) begin
        count_d = count_q + WIDTH'(1);
      end else if (one_shot) begin
        state_d = DONE;
      end else begin
        count_d = '0;
      end
    end
  end

  assign sticky_d = overflow | (sticky_q & ~ovf_clr);

  assign count      = count_q;
  assign ovf_sticky = sticky_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter with hand-computed expectations.
module tb_up_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic       one_shot;
  logic       ovf_clr;
  logic [3:0] count;
  logic       overflow;
  logic       ovf_sticky;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  up_counter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .limit     (limit),
    .one_shot  (one_shot),
    .ovf_clr   (ovf_clr),
    .count     (count),
    .overflow  (overflow),
    .ovf_sticky(ovf_sticky),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] seq [7];
    rst_n    = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    limit    = 4'd0;
    one_shot = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state, with limit=0 and en=1 to show overflow is held low.
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sticky", 32'(ovf_sticky), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Reset and enable: 0..15 then wrap.
    limit = 4'd15;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("run15_count", 32'(count), 32'(i));
      chk("run15_ovf", 32'(overflow), (i == 15) ? 1 : 0);
      tick();
    end
    chk("run15_wrap_count", 32'(count), 0);
    chk("run15_sticky", 32'(ovf_sticky), 1);

    // Short limit: clear sticky, then ovf_clr coinciding with overflow.
    limit   = 4'd5;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("lim5_sticky_clr", 32'(ovf_sticky), 0);
    for (int i = 1; i <= 5; i++) begin
      chk("lim5_count", 32'(count), 32'(i));
      chk("lim5_ovf", 32'(overflow), (i == 5) ? 1 : 0);
      if (i == 5) ovf_clr = 1'b1;
      #1;
      if (i == 5) tick(); else tick();
    end
    ovf_clr = 1'b0;
    chk("lim5_set_wins", 32'(ovf_sticky), 1);
    chk("lim5_wrap", 32'(count), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("lim5_later_clr", 32'(ovf_sticky), 0);
    for (int i = 1; i <= 5; i++) begin
      chk("lim5b_count", 32'(count), 32'(i));
      chk("lim5b_ovf", 32'(overflow), (i == 5) ? 1 : 0);
      tick();
    end
    chk("lim5b_wrap", 32'(count), 0);
    chk("lim5b_sticky", 32'(ovf_sticky), 1);

    // One-shot at limit 3.
    limit    = 4'd3;
    one_shot = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) tick();
    chk("os_count3", 32'(count), 3);
    chk("os_ovf", 32'(overflow), 1);
    chk("os_done_pre", 32'(done), 0);
    tick();
    chk("os_done", 32'(done), 1);
    chk("os_hold", 32'(count), 3);
    chk("os_no_ovf", 32'(overflow), 0);
    tick();
    tick();
    chk("os_hold2", 32'(count), 3);
    chk("os_no_ovf2", 32'(overflow), 0);
    load     = 1'b1;
    load_val = 4'd1;
    tick();
    load = 1'b0;
    #1;
    chk("os_load_count", 32'(count), 1);
    chk("os_load_done", 32'(done), 0);
    tick();
    chk("os_resume", 32'(count), 2);
    one_shot = 1'b0;

    // Priority: clr over load over count at count=limit=15.
    limit    = 4'd15;
    load     = 1'b1;
    load_val = 4'd15;
    tick();
    load = 1'b0;
    #1;
    chk("pri_pre_count", 32'(count), 15);
    chk("pri_pre_ovf", 32'(overflow), 1);
    clr      = 1'b1;
    load     = 1'b1;
    load_val = 4'd9;
    #1;
    chk("pri_ovf", 32'(overflow), 0);
    tick();
    clr  = 1'b0;
    load = 1'b0;
    chk("pri_count", 32'(count), 0);

    // Load above limit: 14,15,0..4 with overflow only at 4.
    limit    = 4'd4;
    load     = 1'b1;
    load_val = 4'd14;
    ovf_clr  = 1'b1;
    tick();
    load    = 1'b0;
    ovf_clr = 1'b0;
    seq[0] = 4'd14; seq[1] = 4'd15; seq[2] = 4'd0; seq[3] = 4'd1;
    seq[4] = 4'd2;  seq[5] = 4'd3;  seq[6] = 4'd4;
    #1;
    for (int i = 0; i < 7; i++) begin
      chk("ab_count", 32'(count), 32'(seq[i]));
      chk("ab_ovf", 32'(overflow), (i == 6) ? 1 : 0);
      if (i == 6) chk("ab_sticky_pre", 32'(ovf_sticky), 0);
      tick();
    end
    chk("ab_wrap", 32'(count), 0);
    chk("ab_sticky", 32'(ovf_sticky), 1);

    // Asynchronous reset from DONE at count 7 with sticky set.
    limit    = 4'd7;
    one_shot = 1'b1;
    load     = 1'b1;
    load_val = 4'd7;
    ovf_clr  = 1'b1;
    tick();
    load    = 1'b0;
    ovf_clr = 1'b0;
    tick();
    chk("ar_pre_done", 32'(done), 1);
    chk("ar_pre_sticky", 32'(ovf_sticky), 1);
    chk("ar_pre_count", 32'(count), 7);
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_sticky", 32'(ovf_sticky), 0);
    chk("ar_ovf", 32'(overflow), 0);
    one_shot = 1'b0;
    rst_n    = 1'b1;
    tick();
    chk("ar_run_count", 32'(count), 1);
    chk("ar_run_done", 32'(done), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
